// File: rtl/operand_fetch.sv
// Operand stage: register-file read, MEM/WB bypass, load-use/RAW hazard stall and ID/EX register.
// Define OPFETCH_FWD_EN to enable bypassing; without it operands wait until the producer has written the register file.
module operand_fetch #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [4:0]    in_rs_i,
    input  logic [4:0]    in_rt_i,
    input  logic [4:0]    in_dst_i,
    input  logic [DW-1:0] in_imm_i,
    input  logic [CW-1:0] in_ctrl_i,
    input  logic          in_reg_wr_i,
    input  logic          in_mem_rd_i,
    output logic [4:0]    rf_raddr1_o,
    output logic [4:0]    rf_raddr2_o,
    input  logic [DW-1:0] rf_rdata1_i,
    input  logic [DW-1:0] rf_rdata2_i,
    input  logic          mem_reg_wr_i,
    input  logic          mem_mem_rd_i,
    input  logic [4:0]    mem_dst_i,
    input  logic [DW-1:0] mem_data_i,
    input  logic          wb_reg_wr_i,
    input  logic [4:0]    wb_dst_i,
    input  logic [DW-1:0] wb_data_i,
    input  logic          flush_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_rs_val_o,
    output logic [DW-1:0] out_rt_val_o,
    output logic [DW-1:0] out_imm_o,
    output logic [CW-1:0] out_ctrl_o,
    output logic [4:0]    out_dst_o,
    output logic          out_reg_wr_o,
    output logic          out_mem_rd_o,
    output logic [15:0]   stall_cnt_o
);

    localparam int NOPS = 2;

    logic [4:0]      op_addr  [NOPS];
    logic [DW-1:0]   op_rdata [NOPS];
    logic [DW-1:0]   op_val   [NOPS];
    logic [NOPS-1:0] op_hz;

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_rs_val_q, out_rt_val_q, out_imm_q;
    logic [CW-1:0]   out_ctrl_q;
    logic [4:0]      out_dst_q;
    logic            out_reg_wr_q, out_mem_rd_q;
    logic [15:0]     stall_cnt_q, stall_cnt_d;
    logic            hz;
    logic            load;

    assign rf_raddr1_o = in_rs_i;
    assign rf_raddr2_o = in_rt_i;

    assign op_addr[0]  = in_rs_i;
    assign op_addr[1]  = in_rt_i;
    assign op_rdata[0] = rf_rdata1_i;
    assign op_rdata[1] = rf_rdata2_i;

    genvar gi;
    generate
        for (gi = 0; gi < NOPS; gi++) begin : g_op
            logic nz;
            logic idex_hit;
            logic mem_hit;
            logic wb_hit;

            // Register 0 is hard-wired, so a dst of 0 can never produce a match.
            assign nz       = (op_addr[gi] != 5'd0);
            assign idex_hit = nz && out_valid_q && out_reg_wr_q && (out_dst_q == op_addr[gi]);
            assign mem_hit  = nz && mem_reg_wr_i && (mem_dst_i == op_addr[gi]);
            assign wb_hit   = nz && wb_reg_wr_i && (wb_dst_i == op_addr[gi]);
`ifdef OPFETCH_FWD_EN
            logic mem_fwd;

            // A load in MEM has only its address on mem_data, so it can't be bypassed yet.
            assign mem_fwd    = mem_hit && !mem_mem_rd_i;
            assign op_val[gi] = !nz     ? '0 :
                                mem_fwd ? mem_data_i :
                                wb_hit  ? wb_data_i :
                                          op_rdata[gi];
            assign op_hz[gi]  = idex_hit || (mem_hit && mem_mem_rd_i);
`else
            assign op_val[gi] = nz ? op_rdata[gi] : '0;
            assign op_hz[gi]  = idex_hit || mem_hit || wb_hit;
`endif
        end
    endgenerate

`ifndef OPFETCH_FWD_EN
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{mem_mem_rd_i, mem_data_i, wb_data_i};
`endif

    assign hz         = in_valid_i && (|op_hz);
    assign in_ready_o = !flush_i && !hz && (!out_valid_q || out_ready_i);
    assign load       = in_valid_i && in_ready_o;

    always_comb begin
        out_valid_d = out_valid_q;
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (hz && !flush_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_rs_val_q <= '0;
            out_rt_val_q <= '0;
            out_imm_q    <= '0;
            out_ctrl_q   <= '0;
            out_dst_q    <= '0;
            out_reg_wr_q <= 1'b0;
            out_mem_rd_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
            // Payload only moves on acceptance so backpressure keeps it stable.
            if (load) begin
                out_rs_val_q <= op_val[0];
                out_rt_val_q <= op_val[1];
                out_imm_q    <= in_imm_i;
                out_ctrl_q   <= in_ctrl_i;
                out_dst_q    <= in_dst_i;
                out_reg_wr_q <= in_reg_wr_i;
                out_mem_rd_q <= in_mem_rd_i;
            end
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_rs_val_o = out_rs_val_q;
    assign out_rt_val_o = out_rt_val_q;
    assign out_imm_o    = out_imm_q;
    assign out_ctrl_o   = out_ctrl_q;
    assign out_dst_o    = out_dst_q;
    assign out_reg_wr_o = out_reg_wr_q;
    assign out_mem_rd_o = out_mem_rd_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized and directed bench for operand_fetch; the reference model tracks in-flight
// producers by stage and resolves each operand to its latest value in program order.
module tb_operand_fetch;

    localparam int DW = 32;
    localparam int CW = 16;
`ifdef OPFETCH_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [4:0]    in_rs, in_rt, in_dst;
    logic [DW-1:0] in_imm;
    logic [CW-1:0] in_ctrl;
    logic          in_reg_wr, in_mem_rd;
    logic [4:0]    rf_raddr1, rf_raddr2;
    logic [DW-1:0] rf_rdata1, rf_rdata2;
    logic          mem_reg_wr, mem_mem_rd;
    logic [4:0]    mem_dst;
    logic [DW-1:0] mem_data;
    logic          wb_reg_wr;
    logic [4:0]    wb_dst;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_rs_val, out_rt_val, out_imm;
    logic [CW-1:0] out_ctrl;
    logic [4:0]    out_dst;
    logic          out_reg_wr, out_mem_rd;
    logic [15:0]   stall_cnt;

    always #5 clk = ~clk;

    operand_fetch #(.DW(DW), .CW(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_rs_i(in_rs), .in_rt_i(in_rt), .in_dst_i(in_dst),
        .in_imm_i(in_imm), .in_ctrl_i(in_ctrl),
        .in_reg_wr_i(in_reg_wr), .in_mem_rd_i(in_mem_rd),
        .rf_raddr1_o(rf_raddr1), .rf_raddr2_o(rf_raddr2),
        .rf_rdata1_i(rf_rdata1), .rf_rdata2_i(rf_rdata2),
        .mem_reg_wr_i(mem_reg_wr), .mem_mem_rd_i(mem_mem_rd),
        .mem_dst_i(mem_dst), .mem_data_i(mem_data),
        .wb_reg_wr_i(wb_reg_wr), .wb_dst_i(wb_dst), .wb_data_i(wb_data),
        .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_rs_val_o(out_rs_val), .out_rt_val_o(out_rt_val),
        .out_imm_o(out_imm), .out_ctrl_o(out_ctrl), .out_dst_o(out_dst),
        .out_reg_wr_o(out_reg_wr), .out_mem_rd_o(out_mem_rd),
        .stall_cnt_o(stall_cnt)
    );

    typedef struct packed {
        logic [4:0]    dst;
        logic          reg_wr;
        logic          mem_rd;
        logic [DW-1:0] result;
        logic [DW-1:0] imm;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] rs_val;
        logic [DW-1:0] rt_val;
    } instr_t;

    // Stage 0 = ID/EX, 1 = MEM, 2 = WB.
    instr_t        pipe [3];
    bit [2:0]      pipe_v;
    logic [DW-1:0] rf [32];
    int            n_tests = 0;
    int            n_fail = 0;
    int            exp_stall = 0;
    int            n_issued = 0;

    assign rf_rdata1  = rf[rf_raddr1];
    assign rf_rdata2  = rf[rf_raddr2];
    assign mem_reg_wr = pipe_v[1] && pipe[1].reg_wr;
    assign mem_mem_rd = pipe_v[1] && pipe[1].mem_rd;
    assign mem_dst    = pipe[1].dst;
    assign mem_data   = pipe[1].mem_rd ? ~pipe[1].result : pipe[1].result;
    assign wb_reg_wr  = pipe_v[2] && pipe[2].reg_wr;
    assign wb_dst     = pipe[2].dst;
    assign wb_data    = pipe[2].result;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int youngest(input logic [4:0] r);
        youngest = -1;
        if (r != 5'd0) begin
            for (int s = 2; s >= 0; s--) begin
                if (pipe_v[s] && pipe[s].reg_wr && pipe[s].dst == r) youngest = s;
            end
        end
    endfunction

    function automatic logic [DW-1:0] value_of(input logic [4:0] r);
        int s;
        s = youngest(r);
        if (r == 5'd0) return '0;
        if (s < 0) return rf[r];
        return pipe[s].result;
    endfunction

    function automatic bit unavailable(input logic [4:0] r);
        int s;
        s = youngest(r);
        if (s < 0) return 1'b0;
        if (FWD) return (s == 0) || (s == 1 && pipe[s].mem_rd);
        return 1'b1;
    endfunction

    // Starts and ends at posedge+1; one clock per call.
    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dst, input logic rw, input logic mr,
                        input logic [DW-1:0] res, input logic fl, input logic orr,
                        output logic acc);
        logic   hz, rdy;
        instr_t ent;
        ent.dst = dst; ent.reg_wr = rw; ent.mem_rd = mr; ent.result = res;
        ent.imm = $urandom; ent.ctrl = CW'($urandom);
        in_valid = v; in_rs = rs; in_rt = rt; in_dst = dst;
        in_imm = ent.imm; in_ctrl = ent.ctrl; in_reg_wr = rw; in_mem_rd = mr;
        flush = fl; out_ready = orr;
        @(negedge clk);
        hz  = v && (unavailable(rs) || unavailable(rt));
        rdy = !fl && !hz && (!pipe_v[0] || orr);
        acc = v && rdy;
        check("in_ready", in_ready, rdy);
        check("out_valid", out_valid, pipe_v[0]);
        check("stall_cnt", stall_cnt, exp_stall);
        check("rf_raddr", {rf_raddr1, rf_raddr2}, {rs, rt});
        if (pipe_v[0]) begin
            check("out_rs_val", out_rs_val, pipe[0].rs_val);
            check("out_rt_val", out_rt_val, pipe[0].rt_val);
            check("out_imm", out_imm, pipe[0].imm);
            check("out_ctrl", out_ctrl, pipe[0].ctrl);
            check("out_dst", out_dst, pipe[0].dst);
            check("out_flags", {out_reg_wr, out_mem_rd}, {pipe[0].reg_wr, pipe[0].mem_rd});
        end
        ent.rs_val = value_of(rs);
        ent.rt_val = value_of(rt);
        if (hz && !fl && exp_stall < 65535) exp_stall++;
        @(posedge clk);
        #1;
        if (pipe_v[2] && pipe[2].reg_wr && pipe[2].dst != 5'd0) rf[pipe[2].dst] = pipe[2].result;
        pipe_v[2] = pipe_v[1];
        pipe[2]   = pipe[1];
        pipe_v[1] = pipe_v[0] && orr && !fl;
        pipe[1]   = pipe[0];
        if (acc) begin
            pipe_v[0] = 1'b1;
            pipe[0]   = ent;
            n_issued++;
            $display("[TB] issue %0d: rs=r%0d(0x%08h) rt=r%0d(0x%08h) dst=r%0d wr=%0b ld=%0b",
                     n_issued, rs, ent.rs_val, rt, ent.rt_val, dst, rw, mr);
        end else if (fl || orr) begin
            pipe_v[0] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, '0, 1'b0, 1'b1, acc);
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                         input logic rw, input logic mr, input logic [DW-1:0] res,
                         output int waited);
        logic acc;
        acc = 1'b0;
        waited = 0;
        while (!acc && waited <= 20) begin
            step(1'b1, rs, rt, dst, rw, mr, res, 1'b0, 1'b1, acc);
            if (!acc) waited++;
        end
        check("issue_accept", acc, 1'b1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_stall_cnt", stall_cnt, 16'd0);
        check("rst_out_rs_val", out_rs_val, '0);
        check("rst_out_imm", out_imm, '0);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        pipe_v = '0;
        exp_stall = 0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic          acc, v, fl, orr, mr, rw;
        int            w;
        logic [DW-1:0] held_imm;
        rst_n = 1'b0;
        in_valid = 1'b0; in_rs = '0; in_rt = '0; in_dst = '0; in_imm = '0; in_ctrl = '0;
        in_reg_wr = 1'b0; in_mem_rd = 1'b0; flush = 1'b0; out_ready = 1'b1;
        pipe_v = '0;
        for (int i = 0; i < 32; i++) pipe[i % 3] = '0;
        rf[0] = '0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 2500; i++) begin
            v   = ($urandom_range(0, 9) < 8);
            fl  = ($urandom_range(0, 19) == 0);
            orr = ($urandom_range(0, 9) < 8);
            mr  = ($urandom_range(0, 9) < 3);
            rw  = mr | ($urandom_range(0, 9) < 7);
            step(v, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 rw, mr, $urandom, fl, orr, acc);
        end

        // ALU producer followed by a dependent reader.
        idle(4);
        issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h0000_1234, w);
        issue(5'd3, 5'd0, 5'd4, 1'b1, 1'b0, $urandom, w);
        check("alu_bubbles", w, FWD ? 1 : 3);
        check("alu_fwd_val", out_rs_val, 32'h0000_1234);

        // Reset while an instruction sits in ID/EX, then a load-use pair.
        do_reset();
        issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 32'hDEAD_BEEF, w);
        issue(5'd1, 5'd5, 5'd6, 1'b1, 1'b0, $urandom, w);
        check("load_bubbles", w, FWD ? 2 : 3);
        check("load_fwd_val", out_rt_val, 32'hDEAD_BEEF);
        check("load_stall_cnt", stall_cnt, FWD ? 2 : 3);

        // Producer with dst 0 sitting in MEM must not feed an r0 operand.
        idle(4);
        issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, w);
        idle(1);
        issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, $urandom, w);
        check("r0_bubbles", w, 0);
        check("r0_val", out_rs_val, '0);

        // Backpressure holds the payload, then the next instruction loads without a bubble.
        idle(4);
        issue(5'd1, 5'd2, 5'd8, 1'b1, 1'b0, $urandom, w);
        held_imm = out_imm;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, $urandom, 1'b0, 1'b0, acc);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_imm_hold", out_imm, held_imm);
        end
        step(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, $urandom, 1'b0, 1'b1, acc);
        check("bp_accept", acc, 1'b1);
        check("bp_next_valid", out_valid, 1'b1);
        check("bp_next_dst", out_dst, 5'd9);

        // Flush together with a valid input.
        step(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, $urandom, 1'b1, 1'b1, acc);
        check("flush_in_ready", in_ready, 1'b0);
        check("flush_out_valid", out_valid, 1'b0);

        // Long hazard: a writer held in ID/EX while a dependent reader waits.
        issue(5'd1, 5'd2, 5'd11, 1'b1, 1'b0, $urandom, w);
        for (int i = 0; i < 70000; i++) begin
            step(1'b1, 5'd11, 5'd0, 5'd12, 1'b1, 1'b0, $urandom, 1'b0, 1'b0, acc);
        end
        check("stall_sat", stall_cnt, 16'hFFFF);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
